// File: rtl/fp_addsub_result_pack.sv
// Normalize, round and pack stage of the FP add/sub datapath (serial normalizer).
// Latency: 4 cycles start-to-valid when already normalized, +1 per shift; 3 for zero.
// Backpressure: none; start_i is ignored while busy_o is high.
module fp_addsub_result_pack #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          sign_i,
    input  logic          zero_flag_i,
    input  logic [EW-1:0] exp_i,
    input  logic [SW+4:0] sum_i,
    input  logic [1:0]    rmode_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [W-1:0]  result_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_PACK,
        S_DONE
    } state_t;

    // Two spare exponent bits absorb the carry and rounding increments past all-ones.
    localparam logic [EW+1:0] EXP_ONE  = {{(EW+1){1'b0}}, 1'b1};
    localparam logic [EW+1:0] EXP_ALL1 = {2'b00, {EW{1'b1}}};

    state_t          state_q, state_d;
    logic            sign_q;
    logic            zero_q;
    logic [EW+1:0]   exp_q;
    logic [SW+4:0]   sum_q;
    logic [1:0]      rmode_q;

    logic            is_zero;
    logic            carry;
    logic            hidden;
    logic            can_shl;
    logic            grs_any;
    logic            inc;
    logic [SW+1:0]   rsum;
    logic [SW-1:0]   frac;
    logic            to_inf;
    logic [W-1:0]    pack_result;
    logic            pack_ovf;
    logic            pack_unf;

    assign is_zero = zero_q | (sum_q == '0);
    assign carry   = sum_q[SW+4];
    assign hidden  = sum_q[SW+3];
    assign can_shl = ~hidden & (exp_q > EXP_ONE);
    assign grs_any = sum_q[2] | sum_q[1] | sum_q[0];
    assign frac    = sum_q[SW+2:3];
    assign rsum    = sum_q[SW+4:3] + {{(SW+1){1'b0}}, inc};
    assign busy_o  = (state_q != S_IDLE);

    always_comb begin
        inc = 1'b0;
        case (rmode_q)
            2'b00:   inc = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_q & grs_any;
            default: inc = sign_q & grs_any;
        endcase
    end

    always_comb begin
        pack_result = '0;
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        to_inf      = (rmode_q == 2'b00) ||
                      (rmode_q == 2'b10 && !sign_q) ||
                      (rmode_q == 2'b11 && sign_q);
        if (is_zero) begin
            pack_result = {(rmode_q == 2'b11), {(W-1){1'b0}}};
        end else if (exp_q >= EXP_ALL1) begin
            pack_ovf = 1'b1;
            if (to_inf)
                pack_result = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
            else
                pack_result = {sign_q, {(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
        end else begin
            pack_result = {sign_q, (hidden ? exp_q[EW-1:0] : {EW{1'b0}}), frac};
            pack_unf    = ~hidden & (frac != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_NORM;
            S_NORM: begin
                if (is_zero)
                    state_d = S_PACK;
                else if (!carry && !can_shl)
                    state_d = S_ROUND;
            end
            S_ROUND: state_d = S_PACK;
            S_PACK:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            exp_q       <= '0;
            sum_q       <= '0;
            rmode_q     <= 2'b00;
            valid_o     <= 1'b0;
            result_o    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sign_q  <= sign_i;
                        zero_q  <= zero_flag_i;
                        exp_q   <= {2'b00, exp_i};
                        sum_q   <= sum_i;
                        rmode_q <= rmode_i;
                    end
                end
                S_NORM: begin
                    if (!is_zero) begin
                        if (carry) begin
                            sum_q <= {1'b0, sum_q[SW+4:2], sum_q[1] | sum_q[0]};
                            exp_q <= exp_q + EXP_ONE;
                        end else if (can_shl) begin
                            sum_q <= {sum_q[SW+3:0], 1'b0};
                            exp_q <= exp_q - EXP_ONE;
                        end
                    end
                end
                S_ROUND: begin
                    // Rounding can only carry out of an all-ones significand.
                    if (rsum[SW+1]) begin
                        sum_q <= {1'b0, rsum[SW+1:1], rsum[0], 2'b00};
                        exp_q <= exp_q + EXP_ONE;
                    end else begin
                        sum_q <= {rsum, 3'b000};
                    end
                end
                S_PACK: begin
                    result_o    <= pack_result;
                    overflow_o  <= pack_ovf;
                    underflow_o <= pack_unf;
                    valid_o     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_result_pack.sv
// Directed bench for fp_addsub_result_pack (single precision).
module tb_fp_addsub_result_pack;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        sign_i;
    logic        zero_flag_i;
    logic [7:0]  exp_i;
    logic [27:0] sum_i;
    logic [1:0]  rmode_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        overflow_o;
    logic        underflow_o;

    int total = 0;
    int bad   = 0;

    fp_addsub_result_pack #(.W(32), .EW(8), .SW(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .sign_i      (sign_i),
        .zero_flag_i (zero_flag_i),
        .exp_i       (exp_i),
        .sum_i       (sum_i),
        .rmode_i     (rmode_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request, returns cycles from accept edge to valid_o (-1 on timeout),
    // then steps into the following cycle so the DUT is idle again.
    task automatic do_op(input logic s, input logic zf, input logic [7:0] e,
                         input logic [27:0] sm, input logic [1:0] rm, output int lat);
        start_i     = 1'b1;
        sign_i      = s;
        zero_flag_i = zf;
        exp_i       = e;
        sum_i       = sm;
        rmode_i     = rm;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            if (valid_o) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0; sign_i = 1'b0; zero_flag_i = 1'b0;
        exp_i = '0; sum_i = '0; rmode_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", result_o); end
        total++; if ({overflow_o, underflow_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow_o, underflow_o}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_one_plus_one();
        int lat;
        do_op(1'b0, 1'b0, 8'd127, 28'h8000000, 2'b00, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL one_plus_one_latency got=%0d exp=5", lat); end
        total++; if (result_o !== 32'h40000000) begin bad++; $display("FAIL one_plus_one_result got=%h exp=40000000", result_o); end
        total++; if ({overflow_o, underflow_o} !== 2'b00) begin bad++; $display("FAIL one_plus_one_flags got=%b exp=00", {overflow_o, underflow_o}); end
    endtask

    task automatic test_zero();
        int lat;
        do_op(1'b1, 1'b1, 8'd100, 28'h4000000, 2'b00, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL zero_rne_latency got=%0d exp=3", lat); end
        total++; if (result_o !== 32'h00000000) begin bad++; $display("FAIL zero_rne_result got=%h exp=00000000", result_o); end
        do_op(1'b0, 1'b1, 8'd100, 28'h4000000, 2'b11, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL zero_rdn_latency got=%0d exp=3", lat); end
        total++; if (result_o !== 32'h80000000) begin bad++; $display("FAIL zero_rdn_result got=%h exp=80000000", result_o); end
        do_op(1'b0, 1'b0, 8'd90, 28'h0, 2'b00, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL zero_sum_latency got=%0d exp=3", lat); end
        total++; if ({result_o, overflow_o, underflow_o} !== 34'h0) begin bad++; $display("FAIL zero_sum_result got=%h exp=00000000", result_o); end
    endtask

    task automatic test_left_shift();
        int lat;
        do_op(1'b0, 1'b0, 8'd127, 28'h0800000, 2'b00, lat);
        total++; if (lat !== 7) begin bad++; $display("FAIL left_shift_latency got=%0d exp=7", lat); end
        total++; if (result_o !== 32'h3E000000) begin bad++; $display("FAIL left_shift_result got=%h exp=3E000000", result_o); end
    endtask

    task automatic test_rounding();
        int lat;
        do_op(1'b0, 1'b0, 8'd127, 28'h7FFFFFC, 2'b00, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL round_carry_latency got=%0d exp=4", lat); end
        total++; if (result_o !== 32'h40000000) begin bad++; $display("FAIL round_carry_result got=%h exp=40000000", result_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL round_carry_ovf got=%b exp=0", overflow_o); end
        do_op(1'b0, 1'b0, 8'd127, 28'h7FFFFFC, 2'b01, lat);
        total++; if (result_o !== 32'h3FFFFFFF) begin bad++; $display("FAIL round_rz got=%h exp=3FFFFFFF", result_o); end
        do_op(1'b1, 1'b0, 8'd127, 28'h7FFFFFC, 2'b10, lat);
        total++; if (result_o !== 32'hBFFFFFFF) begin bad++; $display("FAIL round_rup_neg got=%h exp=BFFFFFFF", result_o); end
        do_op(1'b1, 1'b0, 8'd127, 28'h7FFFFFC, 2'b11, lat);
        total++; if (result_o !== 32'hC0000000) begin bad++; $display("FAIL round_rdn_neg got=%h exp=C0000000", result_o); end
        do_op(1'b0, 1'b0, 8'd127, 28'h4000004, 2'b00, lat);
        total++; if (result_o !== 32'h3F800000) begin bad++; $display("FAIL round_tie_even got=%h exp=3F800000", result_o); end
        do_op(1'b0, 1'b0, 8'd127, 28'h400000C, 2'b00, lat);
        total++; if (result_o !== 32'h3F800002) begin bad++; $display("FAIL round_tie_odd got=%h exp=3F800002", result_o); end
        do_op(1'b0, 1'b0, 8'd127, 28'h4000001, 2'b10, lat);
        total++; if (result_o !== 32'h3F800001) begin bad++; $display("FAIL round_rup_sticky got=%h exp=3F800001", result_o); end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(1'b0, 1'b0, 8'd254, 28'h8000000, 2'b00, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL ovf_latency got=%0d exp=5", lat); end
        total++; if (result_o !== 32'h7F800000) begin bad++; $display("FAIL ovf_rne_result got=%h exp=7F800000", result_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_rne_flag got=%b exp=1", overflow_o); end
        do_op(1'b0, 1'b0, 8'd254, 28'h8000000, 2'b01, lat);
        total++; if (result_o !== 32'h7F7FFFFF) begin bad++; $display("FAIL ovf_rz_result got=%h exp=7F7FFFFF", result_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_rz_flag got=%b exp=1", overflow_o); end
        do_op(1'b1, 1'b0, 8'd254, 28'h8000000, 2'b10, lat);
        total++; if (result_o !== 32'hFF7FFFFF) begin bad++; $display("FAIL ovf_rup_neg got=%h exp=FF7FFFFF", result_o); end
        do_op(1'b1, 1'b0, 8'd254, 28'h8000000, 2'b11, lat);
        total++; if (result_o !== 32'hFF800000) begin bad++; $display("FAIL ovf_rdn_neg got=%h exp=FF800000", result_o); end
    endtask

    task automatic test_underflow();
        int lat;
        do_op(1'b0, 1'b0, 8'd1, 28'h2000000, 2'b00, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL unf_latency got=%0d exp=4", lat); end
        total++; if (result_o !== 32'h00400000) begin bad++; $display("FAIL unf_result got=%h exp=00400000", result_o); end
        total++; if ({overflow_o, underflow_o} !== 2'b01) begin bad++; $display("FAIL unf_flags got=%b exp=01", {overflow_o, underflow_o}); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        lat = -1;
        start_i = 1'b1; sign_i = 1'b0; zero_flag_i = 1'b0;
        exp_i = 8'd127; sum_i = 28'h8000000; rmode_i = 2'b00;
        @(posedge clk); #1;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b exp=1", busy_o); end
        zero_flag_i = 1'b1; rmode_i = 2'b11;
        for (int k = 1; k <= 50; k++) begin
            if (valid_o) begin
                lat = k;
                break;
            end
            if (k == 3) start_i = 1'b0;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        total++; if (lat !== 5) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=5", lat); end
        total++; if (result_o !== 32'h40000000) begin bad++; $display("FAIL busy_ignore_result got=%h exp=40000000", result_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_in_valid_cycle got=%b exp=1", busy_o); end
        @(posedge clk); #1;
        total++; if ({busy_o, valid_o} !== 2'b00) begin bad++; $display("FAIL busy_fall got=%b exp=00", {busy_o, valid_o}); end
        total++; if (result_o !== 32'h40000000) begin bad++; $display("FAIL result_hold got=%h exp=40000000", result_o); end
    endtask

    task automatic test_abort();
        int pulses;
        do_op(1'b0, 1'b0, 8'd1, 28'h2000000, 2'b00, pulses);
        start_i = 1'b1; sign_i = 1'b1; zero_flag_i = 1'b0;
        exp_i = 8'd127; sum_i = 28'h0800000; rmode_i = 2'b00;
        @(posedge clk); #1;
        start_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if ({busy_o, valid_o} !== 2'b00) begin bad++; $display("FAIL abort_busy_valid got=%b exp=00", {busy_o, valid_o}); end
        total++; if (result_o !== 32'h0) begin bad++; $display("FAIL abort_result got=%h exp=00000000", result_o); end
        total++; if ({overflow_o, underflow_o} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b exp=00", {overflow_o, underflow_o}); end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid_o || busy_o) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", pulses); end
    endtask

    initial begin
        test_reset();
        test_one_plus_one();
        test_zero();
        test_left_shift();
        test_rounding();
        test_overflow();
        test_underflow();
        test_busy_ignore();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
